calc_disp_seq: RTL and testbench

//  Display sequencer between calculator core and 8-digit display driver. Accepts a binary

---
 rtl/calc_pkg.sv | 14 +
 rtl/calc_bcd_adj3.sv | 11 +
 rtl/calc_disp_seq.sv | 128 ++++++++++++
 tb/tb_calc_disp_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared status codes, display glyphs and sequencer state type for the calculator display path.
package calc_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} disp_state_t;

endpackage

// File: rtl/calc_bcd_adj3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the shift.
module calc_bcd_adj3 (
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  always_comb begin
    digitOut = (digitIn >= 4'd5) ? digitIn + 4'd3 : digitIn;
  end

endmodule

// File: rtl/calc_disp_seq.sv
// Display sequencer: converts a binary result to BCD by double-dabble and streams
// one blanked digit per cycle to the display driver.
module calc_disp_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int NDIG  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             err,
  output logic [1:0]       status,
  output logic [3:0]       data,
  output logic [3:0]       pos,
  output logic             valid,
  output logic             done
);

  localparam int BW = 4 * (NDIG + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_POS  = 4'(NDIG - 1);

  disp_state_t    state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]  bcd;
  logic [BW-1:0]  bcdAdj;
  logic [BW-1:0]  bcdNext;
  logic [CW-1:0]  cnt;
  logic           errPrint;
  logic           overflow;

  for (genvar g = 0; g < NDIG + 1; g++) begin : gen_adj
    calc_bcd_adj3 u_adj (
      .digitIn (bcd[4*g +: 4]),
      .digitOut(bcdAdj[4*g +: 4])
    );
  end

  // A set top bit of the adjusted register would be shifted out, so it counts as overflow too.
  assign bcdNext  = {bcdAdj[BW-2:0], shreg[WIDTH-1]};
  assign overflow = (bcdNext[4*NDIG +: 4] != 4'd0) || bcdAdj[BW-1];

  // Digit shown at a position: zeros above the highest nonzero digit are blanked, pos 0 never is.
  function automatic logic [3:0] digitAt(input logic [4*NDIG-1:0] b, input logic isErr,
                                         input int idx);
    logic upperZero;
    upperZero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= idx && b[4*i +: 4] != 4'd0) upperZero = 1'b0;
    end
    if (isErr)                     return (idx == 0) ? DIG_ERR : DIG_BLANK;
    else if (idx != 0 && upperZero) return DIG_BLANK;
    else                           return b[4*idx +: 4];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      errPrint <= 1'b0;
      status   <= ST_READY;
      data     <= 4'd0;
      pos      <= 4'd0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (err) begin
              errPrint <= 1'b1;
              status   <= ST_ERR;
              data     <= DIG_ERR;
              pos      <= 4'd0;
              valid    <= 1'b1;
              state    <= EMIT;
            end else begin
              shreg    <= value;
              bcd      <= '0;
              cnt      <= '0;
              errPrint <= 1'b0;
              status   <= ST_BUSY;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          shreg <= shreg << 1;
          bcd   <= bcdNext;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            if (overflow) begin
              errPrint <= 1'b1;
              status   <= ST_ERR;
              data     <= DIG_ERR;
            end else begin
              status <= ST_PRINT;
              data   <= digitAt(bcdNext[4*NDIG-1:0], 1'b0, 0);
            end
            pos   <= 4'd0;
            valid <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (pos == LAST_POS) begin
            valid <= 1'b0;
            pos   <= 4'd0;
            done  <= 1'b1;
            state <= IDLE;
            if (!errPrint) status <= ST_READY;
          end else begin
            pos  <= pos + 4'd1;
            data <= digitAt(bcd[4*NDIG-1:0], errPrint, int'(pos) + 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_disp_seq.sv
// Randomized self-checking bench for calc_disp_seq against a decimal-arithmetic reference model.
module tb_calc_disp_seq;
  import calc_pkg::*;

  localparam int    WIDTH = 27;
  localparam int    NDIG  = 8;
  localparam longint LIMIT = 100000000;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             err;
  logic [WIDTH-1:0] value;
  logic [1:0]       status;
  logic [3:0]       data;
  logic [3:0]       pos;
  logic             valid;
  logic             done;

  int checkCount = 0;
  int errorCount = 0;
  int cyc;

  always #5 clock = ~clock;

  calc_disp_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .value (value),
    .err   (err),
    .status(status),
    .data  (data),
    .pos   (pos),
    .valid (valid),
    .done  (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Decimal view of the print: what a person would expect to read on the display.
  function automatic logic [3:0] modelDigit(input longint v, input bit e, input int idx);
    longint p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (e || v >= LIMIT) return (idx == 0) ? 4'hE : 4'hF;
    if (idx > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Pulses start with junk value/err on the chosen cycle to prove it is ignored.
  task automatic driveInject(input int injectAt);
    if (cyc == injectAt) begin
      start = 1'b1;
      value = WIDTH'($urandom);
      err   = 1'($urandom_range(0, 1));
    end else begin
      start = 1'b0;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] v, input bit e, input int injectAt,
                               input int resetAt);
    bit bad;
    bad = e || (longint'(v) >= LIMIT);
    cyc = 0;
    @(negedge clock);
    value = v;
    err   = e;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    value = WIDTH'($urandom);
    err   = 1'($urandom_range(0, 1));
    if (!e) begin
      for (int k = 0; k < WIDTH; k++) begin
        checkOutput("busyStatus", status, ST_BUSY);
        checkOutput("busyValid", valid, 1'b0);
        driveInject(injectAt);
        @(negedge clock);
      end
    end
    for (int d = 0; d < NDIG; d++) begin
      checkOutput("emitValid", valid, 1'b1);
      checkOutput("emitPos", pos, d);
      checkOutput("emitData", data, modelDigit(longint'(v), e, d));
      checkOutput("emitStatus", status, bad ? ST_ERR : ST_PRINT);
      checkOutput("emitDone", done, 1'b0);
      if (resetAt == d) begin
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rstValid", valid, 1'b0);
        checkOutput("rstPos", pos, 4'd0);
        checkOutput("rstStatus", status, ST_READY);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstData", data, 4'd0);
        reset = 1'b0;
        return;
      end
      driveInject(injectAt);
      @(negedge clock);
    end
    start = 1'b0;
    checkOutput("donePulse", done, 1'b1);
    checkOutput("doneValid", valid, 1'b0);
    checkOutput("doneStatus", status, bad ? ST_ERR : ST_READY);
    @(negedge clock);
    checkOutput("doneLow", done, 1'b0);
    checkOutput("idleStatus", status, bad ? ST_ERR : ST_READY);
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    bit re;
    int mode;
    int inj;
    reset = 1'b1;
    start = 1'b0;
    err   = 1'b0;
    value = '0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("resetStatus", status, ST_READY);
    checkOutput("resetValid", valid, 1'b0);
    checkOutput("resetPos", pos, 4'd0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetData", data, 4'd0);
    reset = 1'b0;

    applyStimulus(27'd1234, 1'b0, -1, -1);
    applyStimulus(27'd0, 1'b0, -1, -1);
    applyStimulus(27'd99999999, 1'b0, -1, -1);
    applyStimulus(27'd100000000, 1'b0, -1, -1);
    repeat (3) @(negedge clock);
    checkOutput("errHeld", status, ST_ERR);
    applyStimulus(27'd5, 1'b1, -1, -1);
    applyStimulus(27'd1234, 1'b0, 10, -1);
    applyStimulus(27'd87654321, 1'b0, 30, -1);
    applyStimulus(27'd1234, 1'b0, -1, 3);
    applyStimulus(27'd4321, 1'b0, -1, -1);

    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rv = WIDTH'($urandom);
        1:       rv = WIDTH'($urandom_range(0, 99999999));
        2:       rv = WIDTH'($urandom_range(0, 999));
        default: rv = WIDTH'($urandom_range(99999990, 100000009));
      endcase
      re  = ($urandom_range(0, 7) == 0);
      inj = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, re ? 7 : 34);
      applyStimulus(rv, re, inj, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
